// File: rtl/renode_axi_sram_subordinate.sv
// AXI4 subordinate backed by a word-addressed internal memory.
// Independent write and read state machines, one outstanding transaction each.
module renode_axi_sram_subordinate #(
    parameter int AddressWidth       = 20,
    parameter int DataWidth          = 32,
    parameter int StrobeWidth        = DataWidth / 8,
    parameter int TransactionIdWidth = 8,
    parameter int MemoryDepth        = 1024
) (
    input  logic                          clk,
    input  logic                          areset_n,
    input  logic [TransactionIdWidth-1:0] awid,
    input  logic [AddressWidth-1:0]       awaddr,
    input  logic [7:0]                    awlen,
    input  logic [2:0]                    awsize,
    input  logic [1:0]                    awburst,
    input  logic                          awlock,
    input  logic [2:0]                    awprot,
    input  logic                          awvalid,
    output logic                          awready,
    input  logic [DataWidth-1:0]          wdata,
    input  logic [StrobeWidth-1:0]        wstrb,
    input  logic                          wlast,
    input  logic                          wvalid,
    output logic                          wready,
    output logic [TransactionIdWidth-1:0] bid,
    output logic [1:0]                    bresp,
    output logic                          bvalid,
    input  logic                          bready,
    input  logic [TransactionIdWidth-1:0] arid,
    input  logic [AddressWidth-1:0]       araddr,
    input  logic [7:0]                    arlen,
    input  logic [2:0]                    arsize,
    input  logic [1:0]                    arburst,
    input  logic                          arlock,
    input  logic [2:0]                    arprot,
    input  logic                          arvalid,
    output logic                          arready,
    output logic [TransactionIdWidth-1:0] rid,
    output logic [DataWidth-1:0]          rdata,
    output logic [1:0]                    rresp,
    output logic                          rlast,
    output logic                          rvalid,
    input  logic                          rready,
    output logic [1:0]                    w_state_dbg,
    output logic                          r_state_dbg
);
    // Handshakes: a transfer happens on the rising edge where valid and ready are both 1;
    // a source holds valid and its payload stable until that edge.
    localparam int IdxW = $clog2(MemoryDepth);
    localparam int OffW = $clog2(StrobeWidth);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    logic [DataWidth-1:0] mem [MemoryDepth];

    function automatic logic in_range(input logic [AddressWidth-1:0] a);
        return (a >> (IdxW + OffW)) == '0;
    endfunction

    function automatic logic [IdxW-1:0] word_idx(input logic [AddressWidth-1:0] a);
        return a[IdxW+OffW-1:OffW];
    endfunction

    function automatic logic [AddressWidth-1:0] next_addr(input logic [AddressWidth-1:0] a,
                                                          input logic [2:0] size,
                                                          input logic [1:0] burst);
        logic [AddressWidth-1:0] step;
        step = AddressWidth'(1) << size;
        if (burst == 2'b00) return a;
        return (a & ~(step - AddressWidth'(1))) + step;
    endfunction

    function automatic logic legal(input logic [2:0] size, input logic [1:0] burst);
        return (32'(size) <= OffW) && (burst[1] == 1'b0);
    endfunction

    logic unused_sideband;
    assign unused_sideband = ^{awlock, awprot, arlock, arprot};

    w_state_t                      w_state;
    logic [AddressWidth-1:0]       w_addr;
    logic [TransactionIdWidth-1:0] w_id;
    logic [7:0]                    w_len, w_cnt;
    logic [2:0]                    w_size;
    logic [1:0]                    w_burst;
    logic                          w_err, w_ill;
    logic                          w_beat, w_beat_ok, w_last_beat, w_beat_err;

    assign w_beat      = (w_state == W_DATA) && wvalid && wready;
    assign w_beat_ok   = !w_ill && in_range(w_addr);
    assign w_last_beat = (w_cnt == w_len);
    // wlast is only audited; the beat counter alone ends the burst.
    assign w_beat_err  = !w_beat_ok || (wlast != w_last_beat);

    always_ff @(posedge clk) begin
        if (w_beat && w_beat_ok) begin
            for (int b = 0; b < StrobeWidth; b++) begin
                if (wstrb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= 2'b00;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
            w_ill   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        w_id    <= awid;
                        w_addr  <= awaddr;
                        w_len   <= awlen;
                        w_size  <= awsize;
                        w_burst <= awburst;
                        w_cnt   <= '0;
                        w_ill   <= !legal(awsize, awburst);
                        w_err   <= !legal(awsize, awburst);
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        w_addr <= next_addr(w_addr, w_size, w_burst);
                        w_cnt  <= w_cnt + 8'd1;
                        w_err  <= w_err | w_beat_err;
                        if (w_last_beat) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bid     <= w_id;
                            bresp   <= (w_err || w_beat_err) ? 2'b10 : 2'b00;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    r_state_t                r_state;
    logic [AddressWidth-1:0] r_addr, r_load_addr;
    logic [7:0]              r_len, r_cnt;
    logic [2:0]              r_size;
    logic [1:0]              r_burst;
    logic                    r_ill, r_load_ill, r_load_ok;

    // Address and legality of the beat that the next load edge will present.
    always_comb begin
        r_load_addr = (r_state == R_IDLE) ? araddr : next_addr(r_addr, r_size, r_burst);
        r_load_ill  = (r_state == R_IDLE) ? !legal(arsize, arburst) : r_ill;
        r_load_ok   = !r_load_ill && in_range(r_load_addr);
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= 2'b00;
            rlast   <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_ill   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        r_addr  <= araddr;
                        r_len   <= arlen;
                        r_size  <= arsize;
                        r_burst <= arburst;
                        r_ill   <= r_load_ill;
                        r_cnt   <= '0;
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rid     <= arid;
                        rdata   <= r_load_ok ? mem[word_idx(r_load_addr)] : '0;
                        rresp   <= r_load_ok ? 2'b00 : 2'b10;
                        rlast   <= (arlen == 8'd0);
                        r_state <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rvalid && rready) begin
                        if (r_cnt == r_len) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_addr <= r_load_addr;
                            r_cnt  <= r_cnt + 8'd1;
                            rdata  <= r_load_ok ? mem[word_idx(r_load_addr)] : '0;
                            rresp  <= r_load_ok ? 2'b00 : 2'b10;
                            rlast  <= ((r_cnt + 8'd1) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign w_state_dbg = w_state;
    assign r_state_dbg = r_state;

endmodule
